// File: rtl/ctrl_config_reloj.sv
// Purpose: steps the user through editing the time, date and timer register groups and commits each group to the register bank.
// Latency: all outputs are registered; a button sampled at edge N is visible after edge N, and LOAD takes exactly one cycle.
// Backpressure: WRITE holds wr_req, the edit data and funcion_conf stable until wr_ack is sampled high; buttons are ignored while it waits.
module ctrl_config_reloj #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_modo,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  input  logic [7:0] cur_f0,
  input  logic [7:0] cur_f1,
  input  logic [7:0] cur_f2,
  input  logic       wr_ack,
  output logic [2:0] funcion_conf,
  output logic [1:0] campo_sel,
  output logic [7:0] ed_f0,
  output logic [7:0] ed_f1,
  output logic [7:0] ed_f2,
  output logic       wr_req,
  output logic       editando
);

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EDIT, S_WRITE} state_t;
  typedef enum logic [1:0] {M_HORA, M_FECHA, M_TIMER} modo_t;

  state_t        state, state_nxt;
  modo_t         modo, modo_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    campo_nxt;
  logic [7:0]    f0_nxt, f1_nxt, f2_nxt;

  // Lowest legal value of a field: day and month start at 1, everything else at 0.
  function automatic logic [7:0] fld_min(input modo_t m, input logic [1:0] idx);
    fld_min = 8'd0;
    if (m == M_FECHA && idx != 2'd2) fld_min = 8'd1;
  endfunction

  // Highest legal value of a field; day-of-month is not checked against the month.
  function automatic logic [7:0] fld_max(input modo_t m, input logic [1:0] idx);
    if (m == M_FECHA) begin
      case (idx)
        2'd0:    fld_max = 8'd31;
        2'd1:    fld_max = 8'd12;
        default: fld_max = 8'd99;
      endcase
    end else begin
      fld_max = (idx == 2'd2) ? 8'd23 : 8'd59;
    end
  endfunction

  // Out-of-range register contents are replaced by the field minimum on load.
  function automatic logic [7:0] fld_load(input modo_t m, input logic [1:0] idx, input logic [7:0] v);
    fld_load = (v < fld_min(m, idx) || v > fld_max(m, idx)) ? fld_min(m, idx) : v;
  endfunction

  function automatic logic [7:0] fld_up(input modo_t m, input logic [1:0] idx, input logic [7:0] v);
    fld_up = (v >= fld_max(m, idx)) ? fld_min(m, idx) : v + 8'd1;
  endfunction

  function automatic logic [7:0] fld_dn(input modo_t m, input logic [1:0] idx, input logic [7:0] v);
    fld_dn = (v <= fld_min(m, idx)) ? fld_max(m, idx) : v - 8'd1;
  endfunction

  function automatic logic [2:0] modo_code(input modo_t m);
    case (m)
      M_HORA:  modo_code = 3'b001;
      M_FECHA: modo_code = 3'b010;
      M_TIMER: modo_code = 3'b100;
      default: modo_code = 3'b000;
    endcase
  endfunction

  // Next-state and next working-copy computation; one button acted on per cycle in EDIT.
  always_comb begin
    state_nxt = state;
    modo_nxt  = modo;
    cnt_nxt   = cnt;
    campo_nxt = campo_sel;
    f0_nxt    = ed_f0;
    f1_nxt    = ed_f1;
    f2_nxt    = ed_f2;
    case (state)
      S_IDLE: begin
        if (btn_modo) begin
          modo_nxt  = M_HORA;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        f0_nxt    = fld_load(modo, 2'd0, cur_f0);
        f1_nxt    = fld_load(modo, 2'd1, cur_f1);
        f2_nxt    = fld_load(modo, 2'd2, cur_f2);
        campo_nxt = 2'd0;
        cnt_nxt   = '0;
        state_nxt = S_EDIT;
      end
      S_EDIT: begin
        cnt_nxt = '0;
        if (btn_modo) begin
          state_nxt = S_WRITE;
        end else if (btn_izq) begin
          campo_nxt = (campo_sel == 2'd0) ? 2'd2 : campo_sel - 2'd1;
        end else if (btn_der) begin
          campo_nxt = (campo_sel == 2'd2) ? 2'd0 : campo_sel + 2'd1;
        end else if (btn_arriba) begin
          case (campo_sel)
            2'd0:    f0_nxt = fld_up(modo, 2'd0, ed_f0);
            2'd1:    f1_nxt = fld_up(modo, 2'd1, ed_f1);
            2'd2:    f2_nxt = fld_up(modo, 2'd2, ed_f2);
            default: ;
          endcase
        end else if (btn_abajo) begin
          case (campo_sel)
            2'd0:    f0_nxt = fld_dn(modo, 2'd0, ed_f0);
            2'd1:    f1_nxt = fld_dn(modo, 2'd1, ed_f1);
            2'd2:    f2_nxt = fld_dn(modo, 2'd2, ed_f2);
            default: ;
          endcase
        end else if (cnt == CNT_LAST) begin
          // Abandon the edit silently; the working copy is left as it was.
          cnt_nxt   = cnt;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_WRITE: begin
        if (wr_ack) begin
          case (modo)
            M_HORA: begin
              modo_nxt  = M_FECHA;
              state_nxt = S_LOAD;
            end
            M_FECHA: begin
              modo_nxt  = M_TIMER;
              state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
          endcase
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, group, counter and output registers; outputs are derived from next-state so they line up with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      modo         <= M_HORA;
      cnt          <= '0;
      campo_sel    <= 2'd0;
      ed_f0        <= 8'd0;
      ed_f1        <= 8'd0;
      ed_f2        <= 8'd0;
      funcion_conf <= 3'b000;
      wr_req       <= 1'b0;
      editando     <= 1'b0;
    end else begin
      state        <= state_nxt;
      modo         <= modo_nxt;
      cnt          <= cnt_nxt;
      campo_sel    <= campo_nxt;
      ed_f0        <= f0_nxt;
      ed_f1        <= f1_nxt;
      ed_f2        <= f2_nxt;
      funcion_conf <= (state_nxt == S_IDLE) ? 3'b000 : modo_code(modo_nxt);
      wr_req       <= (state_nxt == S_WRITE);
      editando     <= (state_nxt == S_EDIT);
    end
  end

endmodule
